fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the URCPU core. It owns the program counter and issues single-outstanding read requests to instruction memory. It captures each returned word into a one-entry output buffer, which it presents to decode with a valid/ready handshake. It accepts a redirect (branch or jump target) at any time and guarantees that no instruction fetched from the old path reaches decode after the redirect edge.

## Interface
- ADDR_W, 8, width of the program counter and instruction address
- DATA_W, 8, instruction word width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- imem_req  out  1  read request to instruction memory
- imem_addr  out  ADDR_W  read address; valid while imem_req=1
- imem_ack  in  1  memory completes the request on this edge; may assert in any cycle imem_req=1, including the first
- imem_rdata  in  DATA_W  read data; valid only when imem_ack=1
- redirect_valid  in  1  single-cycle request to change the fetch PC
- redirect_pc  in  ADDR_W  new PC; sampled when redirect_valid=1
- out_valid  out  1  out_instr/out_pc hold a valid instruction
- out_instr  out  DATA_W  fetched instruction word
- out_pc  out  ADDR_W  address out_instr was fetched from
- out_ready  in  1  decode accepts; transfer on edge with out_valid&out_ready

## Operation
- State machine with states IDLE, FETCH, DRAIN and HOLD.
- All state and outputs are registered; there is no combinational path from inputs to outputs.
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, pending_pc=0.
- The memory request is a transfer on an edge where imem_req=1 and imem_ack=1. Once imem_req is raised, it stays high and imem_addr stays stable until the ack. Requests are never aborted.
- IDLE: go to FETCH on the next edge. If redirect_valid=1, load pc=redirect_pc.
- FETCH: imem_req=1, imem_addr=pc.
  - ack and no redirect: out_instr=imem_rdata, out_pc=pc, out_valid=1, pc=pc+1 modulo 2^ADDR_W (wraps from all-ones to 0), go to HOLD.
  - ack and redirect: discard the data, pc=redirect_pc, stay in FETCH.
  - no ack and redirect: pending_pc=redirect_pc, go to DRAIN.
- DRAIN: imem_req=1, imem_addr=old pc.
  - A redirect overwrites pending_pc; the latest redirect wins.
  - On ack: discard the data, pc=pending_pc (or redirect_pc if a redirect arrives on the same edge), go to FETCH.
- HOLD: imem_req=0, out_valid=1, outputs stable.
  - out_ready and no redirect: out_valid=0, go to FETCH.
  - Redirect: out_valid=0, pc=redirect_pc, go to FETCH. If out_ready=1 on the same edge, the transfer counts as delivered. Otherwise the held instruction is dropped.
- Asynchronous reset mid-request drops the request immediately. Memory must tolerate imem_req falling without an ack during reset.

## Timing
- Reset release edge E0: IDLE→FETCH. imem_req=1 after E0. With ack at E1, out_valid=1 after E1.
- Fetch latency is 1 cycle from imem_req rising to out_valid for a zero-wait memory; each extra wait cycle adds 1.
- Peak throughput is one instruction per 2 cycles: one HOLD cycle, then one FETCH cycle with immediate ack.
- The request goes out with the new pc 1 cycle after the redirect edge, or 1 cycle after the draining ack.
- out_valid never falls without a transfer, except on redirect or reset.

## Structure
- Shared header urcpu_defs.vh holds:
  - state encodings FETCH_IDLE, FETCH_FETCH, FETCH_DRAIN, FETCH_HOLD (2 bits)
  - defaults for ADDR_W, DATA_W and RESET_PC, shared with decode and the memory model
- Sub-module pc_reg: ADDR_W-bit register with async active-low reset to RESET_PC and a load/increment select. It is instantiated once.
- The FSM and output buffer live in fetch_unit.

## Test plan
- Reset with RESET_PC=0, memory returns rdata=addr^8'hA5 with zero wait, out_ready=1 → decode sees pc 0,1,2,3 with instr A5,A4,A7,A6, one every 2 cycles.
- PC at 8'hFF, fetch and accept → out_pc=FF, next request imem_addr=00.
- Memory with 3 wait cycles, redirect_valid to 8'h40 during the second wait → old word is discarded, next imem_addr=40, and no out_valid for the old address.
- Two redirects during DRAIN (8'h10, then 8'h20) → the fetch after the drain uses 8'h20.
- out_ready=0 for 5 cycles in HOLD → out_instr/out_pc stable, imem_req=0 throughout; a redirect to 8'h80 with out_ready=0 drops the instruction, next out_pc=80.
- Assert rst_n=0 while imem_req=1 → imem_req=0, out_valid=0 and imem_addr=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the URCPU fetch stage: state encodings and the
// parameter defaults that decode and the memory model also build against.
package fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_FETCH = 2'd1,
    FETCH_DRAIN = 2'd2,
    FETCH_HOLD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: async reset to RESET_PC, load has priority over
// increment, increment wraps naturally modulo 2^ADDR_W.
module pc_reg #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// URCPU instruction fetch: single-outstanding imem reads, one-entry output
// buffer toward decode, and redirects that never leak old-path instructions.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready,
  output logic [1:0]        dbg_state
);

  // Handshakes: imem transfers on an edge with imem_req & imem_ack, and
  // imem_req/imem_addr hold until then; decode transfers on an edge with
  // out_valid & out_ready, and out_* hold until then unless a redirect drops them.

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pending_pc;
  logic [ADDR_W-1:0] load_pc;
  logic [ADDR_W-1:0] next_addr;
  logic              pc_load;
  logic              pc_inc;

  always_comb begin
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    load_pc = redirect_pc;
    case (state)
      FETCH_IDLE:  pc_load = redirect_valid;
      FETCH_FETCH: begin
        if (imem_ack) begin
          pc_load = redirect_valid;
          pc_inc  = !redirect_valid;
        end
      end
      // A redirect arriving with the draining ack beats the pending target.
      FETCH_DRAIN: begin
        if (imem_ack) begin
          pc_load = 1'b1;
          if (!redirect_valid) load_pc = pending_pc;
        end
      end
      FETCH_HOLD:  pc_load = redirect_valid;
      default:     pc_load = 1'b0;
    endcase
  end

  // Address of the next request whenever the FSM (re)enters FETCH.
  assign next_addr = pc_load ? load_pc : pc;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pc_load),
    .inc     (pc_inc),
    .load_pc (load_pc),
    .pc      (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH_IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
      pending_pc <= '0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          state     <= FETCH_FETCH;
          imem_req  <= 1'b1;
          imem_addr <= next_addr;
        end
        FETCH_FETCH: begin
          if (imem_ack && redirect_valid) begin
            imem_addr <= next_addr;
          end else if (imem_ack) begin
            out_instr <= imem_rdata;
            out_pc    <= pc;
            out_valid <= 1'b1;
            imem_req  <= 1'b0;
            state     <= FETCH_HOLD;
          end else if (redirect_valid) begin
            pending_pc <= redirect_pc;
            state      <= FETCH_DRAIN;
          end
        end
        FETCH_DRAIN: begin
          if (imem_ack) begin
            imem_addr <= next_addr;
            state     <= FETCH_FETCH;
          end else if (redirect_valid) begin
            pending_pc <= redirect_pc;
          end
        end
        FETCH_HOLD: begin
          if (out_ready || redirect_valid) begin
            out_valid <= 1'b0;
            imem_req  <= 1'b1;
            imem_addr <= next_addr;
            state     <= FETCH_FETCH;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked
// against an instruction-stream model (next expected pc, redirect resets it).
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       out_valid;
  logic [7:0] out_instr;
  logic [7:0] out_pc;
  logic       out_ready = 1'b0;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int mem_wait = 0;
  int mem_cnt = 0;
  logic [7:0] mem_key = 8'hA5;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (mem_ack),
    .imem_rdata     (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory model: acks after mem_wait wait cycles, data = addr ^ mem_key.
  always begin
    @(posedge clk);
    #2;
    if (mem_ack) mem_cnt = 0;
    if (!imem_req) begin
      mem_ack = 1'b0;
      mem_cnt = 0;
    end else if (mem_cnt >= mem_wait) begin
      mem_ack   = 1'b1;
      mem_rdata = imem_addr ^ mem_key;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      mem_cnt++;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr, out_valid, out_instr, out_pc} !== 26'h0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b addr=%h v=%b instr=%h pc=%h required all zero",
               imem_req, imem_addr, out_valid, out_instr, out_pc);
    end
    checks++;
    if (dbg_state !== FETCH_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", dbg_state, FETCH_IDLE);
    end
    step();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_req: got %b required 0", imem_req);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00} || dbg_state !== FETCH_FETCH) begin
      errors++;
      $display("FAIL reset_release: got req=%b addr=%h st=%0d required req=1 addr=00 st=1",
               imem_req, imem_addr, dbg_state);
    end
  endtask

  task automatic test_sequential();
    logic [7:0] exp_instr [4];
    exp_instr = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};
    mem_wait = 0;
    mem_key = 8'hA5;
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step();
      checks++;
      if (n % 2 == 1) begin
        if ({out_valid, out_pc, out_instr} !== {1'b1, 8'(n / 2), exp_instr[n / 2]}) begin
          errors++;
          $display("FAIL seq_deliver[%0d]: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                   n, out_valid, out_pc, out_instr, 8'(n / 2), exp_instr[n / 2]);
        end
      end else begin
        if ({out_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'(n / 2)}) begin
          errors++;
          $display("FAIL seq_request[%0d]: got v=%b req=%b addr=%h required v=0 req=1 addr=%h",
                   n, out_valid, imem_req, imem_addr, 8'(n / 2));
        end
      end
    end
  endtask

  task automatic test_wrap();
    mem_wait = 0;
    mem_key = 8'hA5;
    do_reset();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 8'hFF;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL wrap_req_ff: got req=%b addr=%h required req=1 addr=ff", imem_req, imem_addr);
    end
    step();
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 8'hFF, 8'h5A}) begin
      errors++;
      $display("FAIL wrap_deliver_ff: got v=%b pc=%h instr=%h required v=1 pc=ff instr=5a",
               out_valid, out_pc, out_instr);
    end
    step();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL wrap_req_00: got req=%b addr=%h required req=1 addr=00", imem_req, imem_addr);
    end
    step();
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 8'h00, 8'hA5}) begin
      errors++;
      $display("FAIL wrap_deliver_00: got v=%b pc=%h instr=%h required v=1 pc=00 instr=a5",
               out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_redirect_wait();
    mem_wait = 3;
    mem_key = 8'hA5;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      redirect_valid = (i == 2);
      redirect_pc = 8'h40;
      step();
      checks++;
      if (i < 8) begin
        if ({out_valid, imem_req, imem_addr} !== {1'b0, 1'b1, (i < 4) ? 8'h00 : 8'h40}) begin
          errors++;
          $display("FAIL redir_wait[%0d]: got v=%b req=%b addr=%h required v=0 req=1 addr=%h",
                   i, out_valid, imem_req, imem_addr, (i < 4) ? 8'h00 : 8'h40);
        end
      end else if ({out_valid, out_pc, out_instr} !== {1'b1, 8'h40, 8'hE5}) begin
        errors++;
        $display("FAIL redir_wait_deliver: got v=%b pc=%h instr=%h required v=1 pc=40 instr=e5",
                 out_valid, out_pc, out_instr);
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_drain_two();
    mem_wait = 3;
    mem_key = 8'hA5;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      redirect_valid = (i == 1 || i == 2);
      redirect_pc = (i == 1) ? 8'h10 : 8'h20;
      step();
      checks++;
      if (i < 8) begin
        if ({out_valid, imem_req, imem_addr} !== {1'b0, 1'b1, (i < 4) ? 8'h00 : 8'h20}) begin
          errors++;
          $display("FAIL drain_two[%0d]: got v=%b req=%b addr=%h required v=0 req=1 addr=%h",
                   i, out_valid, imem_req, imem_addr, (i < 4) ? 8'h00 : 8'h20);
        end
      end else if ({out_valid, out_pc, out_instr} !== {1'b1, 8'h20, 8'h85}) begin
        errors++;
        $display("FAIL drain_two_deliver: got v=%b pc=%h instr=%h required v=1 pc=20 instr=85",
                 out_valid, out_pc, out_instr);
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_hold_stall();
    mem_wait = 0;
    mem_key = 8'hA5;
    do_reset();
    out_ready = 1'b0;
    step();
    step();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      checks++;
      if ({out_valid, out_pc, out_instr, imem_req} !== {1'b1, 8'h00, 8'hA5, 1'b0}) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got v=%b pc=%h instr=%h req=%b required v=1 pc=00 instr=a5 req=0",
                 k, out_valid, out_pc, out_instr, imem_req);
      end
    end
    redirect_valid = 1'b1;
    redirect_pc = 8'h80;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({out_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'h80}) begin
      errors++;
      $display("FAIL hold_drop: got v=%b req=%b addr=%h required v=0 req=1 addr=80",
               out_valid, imem_req, imem_addr);
    end
    step();
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 8'h80, 8'h25}) begin
      errors++;
      $display("FAIL hold_redirect_deliver: got v=%b pc=%h instr=%h required v=1 pc=80 instr=25",
               out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_async_reset();
    mem_wait = 3;
    mem_key = 8'hA5;
    do_reset();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 8'h33;
    step();
    redirect_valid = 1'b0;
    step();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h33}) begin
      errors++;
      $display("FAIL async_pre: got req=%b addr=%h required req=1 addr=33", imem_req, imem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, out_valid, imem_addr, dbg_state} !== {1'b0, 1'b0, 8'h00, FETCH_IDLE}) begin
      errors++;
      $display("FAIL async_req_drop: got req=%b v=%b addr=%h st=%0d required req=0 v=0 addr=00 st=0",
               imem_req, out_valid, imem_addr, dbg_state);
    end
    mem_wait = 0;
    do_reset();
    out_ready = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL async_hold_drop: got v=%b pc=%h instr=%h required v=0 pc=00 instr=00",
               out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_random();
    logic [7:0] model_pc;
    logic       prev_req, prev_ack, prev_hold;
    logic [7:0] prev_addr, prev_pc, prev_instr;
    int         delivered;
    mem_key = 8'($urandom);
    mem_wait = 0;
    do_reset();
    model_pc = 8'h00;
    delivered = 0;
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc = 8'($urandom);
      mem_wait = $urandom_range(0, 2);
      if (out_valid && out_ready) begin
        checks++;
        if ({out_pc, out_instr} !== {model_pc, model_pc ^ mem_key}) begin
          errors++;
          $display("FAIL rand_deliver[%0d]: got pc=%h instr=%h required pc=%h instr=%h",
                   i, out_pc, out_instr, model_pc, model_pc ^ mem_key);
        end
        model_pc = model_pc + 8'd1;
        delivered++;
      end
      if (redirect_valid) model_pc = redirect_pc;
      prev_req = imem_req;
      prev_ack = mem_ack;
      prev_addr = imem_addr;
      prev_hold = out_valid && !out_ready && !redirect_valid;
      prev_pc = out_pc;
      prev_instr = out_instr;
      step();
      if (prev_req && !prev_ack) begin
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, prev_addr}) begin
          errors++;
          $display("FAIL rand_req_stable[%0d]: got req=%b addr=%h required req=1 addr=%h",
                   i, imem_req, imem_addr, prev_addr);
        end
      end
      if (prev_hold) begin
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, prev_pc, prev_instr}) begin
          errors++;
          $display("FAIL rand_out_stable[%0d]: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                   i, out_valid, out_pc, out_instr, prev_pc, prev_instr);
        end
      end
    end
    redirect_valid = 1'b0;
    checks++;
    if (delivered < 40) begin
      errors++;
      $display("FAIL rand_progress: got %0d deliveries required at least 40", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_redirect_wait();
    test_drain_two();
    test_hold_stall();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
